// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle SLL/SRL/SRA unit, STEP bits per clock, start/busy/done handshake.
// Define ITER_SHIFTER_ROR_EN to add rotate-right on op=11; otherwise op=11 behaves as SRL.
module iter_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   res
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_SHIFT = 2'b01,
      S_DONE  = 2'b10
   } state_e;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROR = 2'b11
   } op_e;

   state_e             state;
   op_e                op_r;
   logic [WIDTH-1:0]   work;
   logic [WIDTH-1:0]   shifted;
   logic [SHAMT_W-1:0] remaining;
   logic [SHAMT_W-1:0] step_amt;

   // Last step may be shorter than STEP when shamt is not a multiple of it.
   always_comb begin
      step_amt = (int'(remaining) < STEP) ? remaining : SHAMT_W'(STEP);
      case (op_r)
         OP_SLL:  shifted = work << step_amt;
         OP_SRA:  shifted = $signed(work) >>> step_amt;
`ifdef ITER_SHIFTER_ROR_EN
         OP_ROR:  shifted = (work >> step_amt) | (work << (WIDTH - int'(step_amt)));
`endif
         default: shifted = work >> step_amt;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         op_r      <= OP_SLL;
         work      <= '0;
         remaining <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         res       <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  work      <= data_in;
                  op_r      <= op_e'(op);
                  remaining <= shamt;
                  busy      <= 1'b1;
                  if (shamt == '0) begin
                     res   <= data_in;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     state <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               work      <= shifted;
               remaining <= remaining - step_amt;
               if (remaining == step_amt) begin
                  res   <= shifted;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
